// File: rtl/vpu_sram_lsu.sv
// Vector load/store unit: moves one VPU register image between the vector datapath
// and the TPC-local SRAM port, one SRAM word per beat.
module vpu_sram_lsu #(
  parameter int VPU_LANES = 16,
  parameter int ELEM_W    = 32,
  parameter int SRAM_W    = 256,
  parameter int ADDR_W    = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_store,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [15:0]                   cmd_count,
  input  logic [VPU_LANES*ELEM_W-1:0]   vec_wdata,
  output logic [VPU_LANES*ELEM_W-1:0]   vec_rdata,
  output logic                          vec_rvalid,
  output logic                          cmd_done,
  output logic                          cmd_err,
  output logic                          sram_req,
  input  logic                          sram_gnt,
  output logic                          sram_we,
  output logic [ADDR_W-6:0]             sram_addr,
  output logic [SRAM_W-1:0]             sram_wdata,
  output logic [SRAM_W/8-1:0]           sram_wmask,
  input  logic                          sram_rvalid,
  input  logic [SRAM_W-1:0]             sram_rdata
);

  localparam int VEC_W     = VPU_LANES * ELEM_W;
  localparam int WORD_B    = SRAM_W / 8;
  localparam int OFF_W     = $clog2(WORD_B);
  localparam int WA_W      = ADDR_W - OFF_W;
  localparam int MAX_BEATS = VEC_W / SRAM_W;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int CNT_W     = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]        state;
  logic [WA_W-1:0]   waddr_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;
  logic [BEAT_W-1:0] nbeats_q;
  logic [BEAT_W-1:0] issued_q;
  logic [BEAT_W-1:0] rcvd_q;
  logic [VEC_W-1:0]  wbuf_q;
  logic [VEC_W-1:0]  rbuf_q;
  logic [VEC_W-1:0]  rbuf_nxt;
  logic              last_issue;
  logic              last_rcv;

  // Number of SRAM words touched by a vector of cnt elements.
  function automatic logic [BEAT_W-1:0] calc_nbeats(input logic [CNT_W-1:0] cnt);
    logic [31:0] bits;
    bits = 32'(cnt) * 32'(ELEM_W);
    return BEAT_W'((bits + 32'(SRAM_W - 1)) / 32'(SRAM_W));
  endfunction

  // Byte mask of the final beat; a vector ending on a word boundary writes the full word.
  function automatic logic [WORD_B-1:0] last_mask(input logic [CNT_W-1:0] cnt);
    logic [31:0]       rem;
    logic [WORD_B-1:0] m;
    rem = (32'(cnt) * 32'(ELEM_W / 8)) % 32'(WORD_B);
    m   = '1;
    if (rem != 32'd0) begin
      for (int i = 0; i < WORD_B; i++) m[i] = (32'(i) < rem);
    end
    return m;
  endfunction

  function automatic logic [VEC_W-1:0] zero_lanes(input logic [VEC_W-1:0] v,
                                                  input logic [CNT_W-1:0] cnt);
    logic [VEC_W-1:0] r;
    r = v;
    for (int l = 0; l < VPU_LANES; l++) begin
      if (32'(l) >= 32'(cnt)) r[l*ELEM_W +: ELEM_W] = '0;
    end
    return r;
  endfunction

  assign cmd_ready  = (state == IDLE);
  assign cmd_done   = (state == FIN);
  assign cmd_err    = (state == FIN) && err_q;
  assign last_issue = (issued_q == nbeats_q - BEAT_W'(1));
  assign last_rcv   = (rcvd_q == nbeats_q - BEAT_W'(1));

  always_comb begin
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (state == RD && issued_q < nbeats_q) begin
      sram_req  = 1'b1;
      sram_addr = waddr_q;
    end else if (state == WR) begin
      sram_req   = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = waddr_q;
      sram_wdata = wbuf_q[int'(issued_q)*SRAM_W +: SRAM_W];
      sram_wmask = last_issue ? last_mask(count_q) : '1;
    end
  end

  // Result image with the returning word merged in at its slot.
  always_comb begin
    rbuf_nxt = rbuf_q;
    if (int'(rcvd_q) < MAX_BEATS) rbuf_nxt[int'(rcvd_q)*SRAM_W +: SRAM_W] = sram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      waddr_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      nbeats_q   <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      vec_rdata  <= '0;
      vec_rvalid <= 1'b0;
    end else begin
      vec_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            waddr_q  <= cmd_addr[ADDR_W-1:OFF_W];
            count_q  <= cmd_count;
            nbeats_q <= calc_nbeats(cmd_count);
            issued_q <= '0;
            rcvd_q   <= '0;
            if (cmd_count == '0) begin
              err_q <= 1'b0;
              state <= FIN;
            end else if (cmd_count > CNT_W'(VPU_LANES) || cmd_addr[OFF_W-1:0] != '0) begin
              err_q <= 1'b1;
              state <= FIN;
            end else begin
              err_q <= 1'b0;
              state <= cmd_store ? WR : RD;
            end
          end
        end
        RD: begin
          if (sram_req && sram_gnt) begin
            issued_q <= issued_q + BEAT_W'(1);
            waddr_q  <= waddr_q + WA_W'(1);
          end
          if (sram_rvalid) begin
            rcvd_q <= rcvd_q + BEAT_W'(1);
            if (last_rcv) begin
              vec_rdata  <= zero_lanes(rbuf_nxt, count_q);
              vec_rvalid <= 1'b1;
              state      <= FIN;
            end
          end
        end
        WR: begin
          if (sram_gnt) begin
            issued_q <= issued_q + BEAT_W'(1);
            waddr_q  <= waddr_q + WA_W'(1);
            if (last_issue) state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data-only staging buffers; their contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (cmd_ready && cmd_valid && cmd_store) wbuf_q <= vec_wdata;
    if (state == RD && sram_rvalid) rbuf_q <= rbuf_nxt;
  end

endmodule
